// File: rtl/ram_arbiter.sv
// Round-robin two-master arbiter and fixed-window access sequencer for one external SRAM.
// Ack arrives WAIT+1 cycles after the granting edge; a losing master keeps req high until its own ack.
module ram_arbiter #(
  parameter int AW   = 19,
  parameter int DW   = 16,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          sram_oe,
  output logic          sram_we,
  output logic          sram_be,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WCNT_LOAD = 4'(WAIT - 1);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          dir_we_q, dir_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          be_q, be_d;
  logic          oe_q, oe_d;
  logic          swe_q, swe_d;
  logic          busy_q, busy_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          gnt;
  logic          gnt_we;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    wcnt_d   = wcnt_q;
    dir_we_d = dir_we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    oe_d     = oe_q;
    swe_d    = swe_q;
    busy_d   = busy_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt      = 1'b0;
    gnt_we   = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the master that did not win last time goes first.
        if (m0_req && m1_req) gnt = ~last_q;
        else                  gnt = m1_req;
        gnt_we = gnt ? m1_we : m0_we;
        if (m0_req || m1_req) begin
          state_d  = ACCESS;
          owner_d  = gnt;
          last_d   = gnt;
          wcnt_d   = WCNT_LOAD;
          dir_we_d = gnt_we;
          addr_d   = gnt ? m1_addr  : m0_addr;
          wdata_d  = gnt ? m1_wdata : m0_wdata;
          be_d     = gnt ? m1_be    : m0_be;
          oe_d     = ~gnt_we;
          swe_d    = gnt_we;
          busy_d   = 1'b1;
        end
      end

      ACCESS: begin
        if (wcnt_q == 4'd0) begin
          state_d = DONE;
          oe_d    = 1'b0;
          swe_d   = 1'b0;
          if (!dir_we_q) begin
            if (owner_q) rdata1_d = sram_rdata;
            else         rdata0_d = sram_rdata;
          end
          if (owner_q) ack1_d = 1'b1;
          else         ack0_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
        swe_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      wcnt_q   <= 4'd0;
      dir_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 1'b0;
      oe_q     <= 1'b0;
      swe_q    <= 1'b0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      wcnt_q   <= wcnt_d;
      dir_we_q <= dir_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      oe_q     <= oe_d;
      swe_q    <= swe_d;
      busy_q   <= busy_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_be    = be_q;
  assign sram_oe    = oe_q;
  assign sram_we    = swe_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign m0_ack     = ack0_q;
  assign m1_ack     = ack1_q;
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: SRAM model, request driver and an ack scoreboard fed at request time.
module tb_ram_arbiter;
  localparam int AW   = 19;
  localparam int DW   = 16;
  localparam int WAIT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m0_be = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m1_req = 1'b0, m1_we = 1'b0, m1_be = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          sram_oe, sram_we, sram_be, busy, owner;

  ram_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_oe(sram_oe), .sram_we(sram_we), .sram_be(sram_be),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // SRAM: synchronous write, asynchronous read gated by the read strobe.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_dat = '0;
  always @(posedge clk) begin
    if (pl_en)        sram_mem[pl_addr] <= pl_dat;
    else if (sram_we) sram_mem[sram_addr] <= sram_wdata;
  end
  assign sram_rdata = sram_oe ? sram_mem[sram_addr] : '0;

  typedef struct { bit m; logic [DW-1:0] rdata; int cyc; } exp_t;
  typedef struct { bit m; int cyc; } ack_t;

  exp_t          exp_q[$];
  ack_t          ack_log[$];
  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_rdata [2];
  int            total = 0;
  int            bad = 0;
  int            ncyc = 0;
  int            oe_cnt = 0;
  int            we_cnt = 0;

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : '0;
  endfunction

  // Scoreboard: every ack is matched against the oldest expected transaction.
  exp_t          mon_e;
  ack_t          mon_a;
  logic [DW-1:0] mon_rd;
  always @(negedge clk) begin
    if (sram_oe) oe_cnt++;
    if (sram_we) we_cnt++;
    if (m0_ack || m1_ack) begin
      mon_a.m   = m1_ack;
      mon_a.cyc = ncyc;
      mon_rd    = m1_ack ? m1_rdata : m0_rdata;
      ack_log.push_back(mon_a);
      total++;
      if (m0_ack && m1_ack) begin
        bad++;
        $display("FAIL sb_dual_ack: both acks high at cycle %0d, required one", ncyc);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack: m%0d ack at cycle %0d, required none", mon_a.m, ncyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a.m !== mon_e.m || mon_rd !== mon_e.rdata || owner !== mon_e.m) begin
          bad++;
          $display("FAIL sb_ack: got m%0d rdata=%h owner=%0d, required m%0d rdata=%h",
                   mon_a.m, mon_rd, owner, mon_e.m, mon_e.rdata);
        end
        if (mon_e.cyc >= 0) begin
          total++;
          if (ncyc != mon_e.cyc) begin
            bad++;
            $display("FAIL sb_ack_cycle: m%0d ack at cycle %0d, required %0d",
                     mon_a.m, ncyc, mon_e.cyc);
          end
        end
      end
    end
    ncyc++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // dly: expected ack cycle offset from now, or -1 when timing is not checked.
  task automatic issue(input bit m, input bit we, input bit be, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int dly, input bit push);
    exp_t e;
    if (push) begin
      if (we) model_mem[int'(a)] = d;
      else    exp_rdata[m] = mread(a);
      e.m     = m;
      e.rdata = exp_rdata[m];
      e.cyc   = (dly < 0) ? -1 : ncyc + dly;
      exp_q.push_back(e);
    end
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_be = be; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_be = be; m0_addr = a; m0_wdata = d;
    end
  endtask

  // Drops each req on its ack; optionally re-raises it one cycle later as a fresh read.
  task automatic wait_acks(input int n, input int budget, input int reissue, output bit ok);
    int  base;
    int  left;
    bit  re0, re1;
    base = ack_log.size();
    left = reissue;
    re0  = 1'b0;
    re1  = 1'b0;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (re0) begin issue(1'b0, 1'b0, 1'b0, 19'h00100, 16'h0, -1, 1'b1); re0 = 1'b0; end
      if (re1) begin issue(1'b1, 1'b0, 1'b0, 19'h7FFFF, 16'h0, -1, 1'b1); re1 = 1'b0; end
      if (m0_ack) begin m0_req = 1'b0; if (left > 0) begin re0 = 1'b1; left--; end end
      if (m1_ack) begin m1_req = 1'b0; if (left > 0) begin re1 = 1'b1; left--; end end
      if (ack_log.size() - base >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step();
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    model_mem[int'(a)] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    preload(19'h00100, 16'hBEEF);
    preload(19'h00200, 16'h5A5A);
    step();
    total++;
    if ({sram_oe, sram_we, sram_be, busy, owner, m0_ack, m1_ack} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: oe,we,be,busy,owner,ack0,ack1=%b, required 0000000",
               {sram_oe, sram_we, sram_be, busy, owner, m0_ack, m1_ack});
    end
    total++;
    if (sram_addr !== '0 || sram_wdata !== '0) begin
      bad++;
      $display("FAIL reset_sram_bus: addr=%h wdata=%h, required 0", sram_addr, sram_wdata);
    end
    total++;
    if (m0_rdata !== '0 || m1_rdata !== '0) begin
      bad++;
      $display("FAIL reset_rdata: m0=%h m1=%h, required 0", m0_rdata, m1_rdata);
    end
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    reset = 1'b1;
  endtask

  task automatic test_tie_after_reset();
    bit ok;
    int b;
    b = ack_log.size();
    issue(1'b0, 1'b0, 1'b0, 19'h00100, 16'h0, WAIT, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 19'h00200, 16'h0, 2*WAIT + 2, 1'b1);
    wait_acks(2, 20, 0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL tie_timeout: %0d acks, required 2", ack_log.size() - b);
    end else begin
      total++;
      if (ack_log[b].m !== 1'b0 || ack_log[b+1].m !== 1'b1) begin
        bad++;
        $display("FAIL tie_order: owners %0d,%0d, required 0,1", ack_log[b].m, ack_log[b+1].m);
      end
    end
  endtask

  task automatic test_single_read();
    bit ok;
    step();
    oe_cnt = 0;
    we_cnt = 0;
    issue(1'b0, 1'b0, 1'b0, 19'h00100, 16'h0, WAIT, 1'b1);
    wait_acks(1, 10, 0, ok);
    step();
    step();
    total++;
    if (!ok || oe_cnt != WAIT || we_cnt != 0) begin
      bad++;
      $display("FAIL single_read_strobes: ok=%0d oe_cycles=%0d we_cycles=%0d, required 1 %0d 0",
               ok, oe_cnt, we_cnt, WAIT);
    end
    total++;
    if (busy !== 1'b0 || m0_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL single_read_hold: busy=%b m0_rdata=%h, required 0 BEEF", busy, m0_rdata);
    end
  endtask

  task automatic test_write_readback();
    bit ok;
    oe_cnt = 0;
    we_cnt = 0;
    issue(1'b1, 1'b1, 1'b1, 19'h7FFFF, 16'h1234, WAIT, 1'b1);
    step();
    total++;
    if ({sram_we, sram_oe, sram_be, busy, owner} !== 5'b10111 ||
        sram_addr !== 19'h7FFFF || sram_wdata !== 16'h1234) begin
      bad++;
      $display("FAIL write_access: we,oe,be,busy,owner=%b addr=%h wdata=%h, required 10111 7ffff 1234",
               {sram_we, sram_oe, sram_be, busy, owner}, sram_addr, sram_wdata);
    end
    wait_acks(1, 10, 0, ok);
    step();
    total++;
    if (!ok || we_cnt != WAIT || oe_cnt != 0 || sram_addr !== 19'h7FFFF) begin
      bad++;
      $display("FAIL write_window: ok=%0d we_cycles=%0d oe_cycles=%0d addr=%h, required 1 %0d 0 7ffff",
               ok, we_cnt, oe_cnt, sram_addr, WAIT);
    end
    issue(1'b1, 1'b0, 1'b0, 19'h7FFFF, 16'h0, WAIT, 1'b1);
    wait_acks(1, 10, 0, ok);
    total++;
    if (!ok || m1_rdata !== 16'h1234 || m0_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL readback: ok=%0d m1_rdata=%h m0_rdata=%h, required 1 1234 BEEF",
               ok, m1_rdata, m0_rdata);
    end
  endtask

  task automatic test_contention();
    bit   ok;
    int   b;
    ack_t p, a;
    step();
    b = ack_log.size();
    // The previous grant went to m1, so m0 wins the opening tie.
    issue(1'b0, 1'b0, 1'b0, 19'h00100, 16'h0, -1, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 19'h7FFFF, 16'h0, -1, 1'b1);
    wait_acks(8, 80, 6, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL contention_timeout: %0d acks, required 8", ack_log.size() - b);
    end else begin
      for (int i = 1; i < 8; i++) begin
        p = ack_log[b+i-1];
        a = ack_log[b+i];
        total++;
        if (a.m === p.m || a.cyc - p.cyc != WAIT + 2) begin
          bad++;
          $display("FAIL contention_step%0d: m%0d after m%0d spacing %0d, required other master spacing %0d",
                   i, a.m, p.m, a.cyc - p.cyc, WAIT + 2);
        end
      end
    end
  endtask

  task automatic test_abandoned();
    bit ok;
    int n;
    step();
    issue(1'b0, 1'b0, 1'b0, 19'h00200, 16'h0, WAIT, 1'b1);
    step();
    m0_req = 1'b0;
    wait_acks(1, 10, 0, ok);
    n = ack_log.size();
    repeat (5) step();
    total++;
    if (!ok || ack_log.size() != n || busy !== 1'b0 || sram_oe !== 1'b0) begin
      bad++;
      $display("FAIL abandoned: ok=%0d extra_acks=%0d busy=%b oe=%b, required 1 0 0 0",
               ok, ack_log.size() - n, busy, sram_oe);
    end
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    int n;
    step();
    n = ack_log.size();
    issue(1'b1, 1'b1, 1'b0, 19'h00300, 16'hCAFE, -1, 1'b0);
    step();
    step();
    total++;
    if (sram_we !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: sram_we=%b busy=%b, required 1 1", sram_we, busy);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({sram_we, sram_oe, busy, owner} !== 4'b0 || sram_addr !== '0 ||
        sram_wdata !== '0 || m1_rdata !== '0 || m0_rdata !== '0) begin
      bad++;
      $display("FAIL midreset_async: we,oe,busy,owner=%b addr=%h wdata=%h rd1=%h rd0=%h, required all 0",
               {sram_we, sram_oe, busy, owner}, sram_addr, sram_wdata, m1_rdata, m0_rdata);
    end
    m1_req = 1'b0;
    m1_we  = 1'b0;
    repeat (3) step();
    total++;
    if (ack_log.size() != n || m1_ack !== 1'b0) begin
      bad++;
      $display("FAIL midreset_ack: %0d acks m1_ack=%b, required 0 0", ack_log.size() - n, m1_ack);
    end
    reset = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    step();
    issue(1'b0, 1'b0, 1'b0, 19'h00100, 16'h0, WAIT, 1'b1);
    wait_acks(1, 10, 0, ok);
    total++;
    if (!ok || m0_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL post_reset_read: ok=%0d m0_rdata=%h, required 1 BEEF", ok, m0_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_tie_after_reset();
    test_single_read();
    test_write_readback();
    test_contention();
    test_abandoned();
    test_reset_mid_access();
    repeat (3) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d transactions never acked, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter and access sequencer for the single external 16-bit SRAM. Master 0 is the CPU memory port; master 1 is the DMA/boot-loader port. The block grants the SRAM to one master per transaction, drives the SRAM control lines for a fixed access window, and returns read data with a one-cycle acknowledge. It sits between the CPU/loader address and data buses and the SRAM pins, after paging translation.

## Interface
Parameters:
- AW, 19: SRAM address width.
- DW, 16: data width.
- WAIT, 2: SRAM access cycles per transaction (legal range 1–15).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_be  in  1  byte-access flag, passed through to the SRAM.
- m0_addr  in  AW  address.
- m0_wdata  in  DW  write data.
- m0_rdata  out  DW  read data, valid while m0_ack = 1.
- m0_ack  out  1  one-cycle completion pulse.
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_rdata, m1_ack: same as the m0_* ports, for master 1.
- sram_addr  out  AW  registered address.
- sram_wdata  out  DW  registered write data.
- sram_rdata  in  DW  SRAM read data.
- sram_oe  out  1  read strobe.
- sram_we  out  1  write strobe.
- sram_be  out  1  byte-access flag.
- busy  out  1  high in ACCESS and DONE.
- owner  out  1  index of the master currently or last granted.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE**
  - With no request, stay in IDLE.
  - With exactly one request, grant that master.
  - With both requests, grant the master not granted last. This is round-robin; the `last` pointer resets to 1, so master 0 wins the first tie.
  - On grant: latch addr, we, be and wdata into the sram_* registers; set owner; update `last`; load wcnt = WAIT−1; go to ACCESS.
- **ACCESS**
  - Drive sram_oe = ~we and sram_we = we on every ACCESS cycle.
  - Decrement wcnt each cycle.
  - When wcnt = 0: capture sram_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), then go to DONE.
- **DONE**
  - Assert the owner's ack for exactly one cycle. sram_oe and sram_we are 0.
  - Requests are ignored in DONE. Return to IDLE.
- Requesters must drop req in the cycle after ack. A req still high in IDLE starts a new transaction.
- Requests are not abortable. If req falls during ACCESS, the transaction still completes and ack is still issued.
- The non-owner's req is held pending and is not acknowledged until its own grant.
- m*_rdata holds its last captured value between transactions.
- Arithmetic: wcnt is 4 bits and counts down only; no wrap is possible within the legal WAIT range.

## Timing
- All outputs are registered. Reset values: sram_* = 0, sram_oe = 0, sram_we = 0, m*_ack = 0, m*_rdata = 0, busy = 0, owner = 0, state = IDLE, last = 1.
- Asserting reset low takes effect immediately, with no clock. Reset mid-ACCESS drops the transaction, deasserts the strobes at once, and issues no ack.
- Latency: req sampled high at edge N → ACCESS in cycles N+1 … N+WAIT → ack high in cycle N+WAIT+1.
- Throughput: the minimum spacing between grants is WAIT+2 cycles. Under continuous dual contention, grants alternate 0,1,0,1.
- sram_addr, sram_wdata and sram_be stay stable through the whole ACCESS window and hold their values in DONE and IDLE.
- The SRAM must present sram_rdata by the last ACCESS rising edge.
- When both reqs rise in the same cycle as a return to IDLE, arbitration uses the `last` value updated by the just-finished grant.

## Test plan
- **Single read:** WAIT=2, SRAM[0x00100] = 0xBEEF, m0 reads 0x00100 → sram_oe high for 2 cycles; m0_ack at req+3; m0_rdata = 0xBEEF.
- **Write then readback:** m1 writes 0x1234 to 0x7FFFF (sram_we high for 2 cycles, m1_ack at req+3), then m1 reads 0x7FFFF → 0x1234; m0_rdata unchanged throughout.
- **Tie after reset:** m0 and m1 both assert req in the first cycle → m0 granted first, m1 granted in the next IDLE; acks 4 cycles apart; owner sequence 0,1.
- **Sustained contention:** both reqs re-asserted immediately after each ack for 8 transactions → strict alternation, each ack exactly 4 cycles apart; no master starved.
- **Abandoned request:** m0_req drops in mid-ACCESS → m0_ack still pulses once; next IDLE with no requests stays idle.
- **Reset mid-access:** reset low during ACCESS of an m1 write → sram_we = 0 immediately, no m1_ack, all outputs at reset values; after release, an m0 read completes normally.
